// File: rtl/pix_pkg.sv
// ---------------------------------------------------------------------------
// pix_pkg
// Shared types and constants for the pixel-coordinate scanner and the blocks
// that reuse its lane-mask logic (e.g. the write-back collector).
//
// Contents:
//   scan_state_t   - scanner FSM states (IDLE, RUN, DONE)
//   PIX_X_BITS     - default width of x coordinates / x extent
//   PIX_Y_BITS     - default width of y coordinates / y extent
//   PIX_NUM_LANES  - default number of pixels issued per beat
//   laneExtBits()  - width needed to add a lane offset to an x coordinate
//                    without wrapping
// ---------------------------------------------------------------------------
package pix_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } scan_state_t;

   localparam int PIX_X_BITS    = 10;
   localparam int PIX_Y_BITS    = 10;
   localparam int PIX_NUM_LANES = 4;

   // An x coordinate can be as large as 2^xBits-1 and a lane offset as large
   // as lanes, so the sum needs enough headroom bits to hold both without
   // wrapping back into the valid range.
   function automatic int laneExtBits(input int xBits, input int lanes);
      return xBits + $clog2(lanes + 1);
   endfunction

endpackage : pix_pkg

// File: rtl/pix_lane_mask.sv
// ---------------------------------------------------------------------------
// pix_lane_mask
// Purely combinational helper that decides, for a beat starting at column
// i_baseX, which of the NUM_LANES adjacent pixels fall inside the row and
// whether this beat is the last one of the row.
//
// Ports:
//   i_baseX     in  X_BITS     column of lane 0
//   i_xMax      in  X_BITS     last valid column index of the row
//   o_laneMask  out NUM_LANES  bit i set when i_baseX+i <= i_xMax
//   o_rowLast   out 1          set when i_baseX+NUM_LANES > i_xMax
// ---------------------------------------------------------------------------
module pix_lane_mask
   import pix_pkg::*;
#(
   parameter int X_BITS    = PIX_X_BITS,
   parameter int NUM_LANES = PIX_NUM_LANES
) (
   input  logic [X_BITS-1:0]    i_baseX,
   input  logic [X_BITS-1:0]    i_xMax,
   output logic [NUM_LANES-1:0] o_laneMask,
   output logic                 o_rowLast
);

   localparam int EXT_BITS = laneExtBits(X_BITS, NUM_LANES);

   logic [EXT_BITS-1:0] w_baseExt;
   logic [EXT_BITS-1:0] w_xMaxExt;

   // Widen both operands so base+offset cannot wrap when the row ends near
   // the top of the coordinate range.
   assign w_baseExt = EXT_BITS'(i_baseX);
   assign w_xMaxExt = EXT_BITS'(i_xMax);

   // One comparator per lane: a lane is live while its column is still at or
   // left of the row's last column, which gives a partial mask on the tail.
   always_comb begin
      o_laneMask = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         o_laneMask[i] = ((w_baseExt + EXT_BITS'(i)) <= w_xMaxExt);
      end
   end

   // The beat is the last of its row when the next beat would start past
   // the row's last column.
   assign o_rowLast = ((w_baseExt + EXT_BITS'(NUM_LANES)) > w_xMaxExt);

endmodule : pix_lane_mask

// File: rtl/pix_scan.sv
// ---------------------------------------------------------------------------
// pix_scan
// Row-major pixel-coordinate scanner feeding NUM_LANES parallel iteration
// engines. Frame extents are latched on start; each beat carries the column
// of lane 0, the row, a mask of in-frame lanes and row/frame boundary flags.
//
// Ports:
//   clk             in  1          system clock, rising edge
//   rst             in  1          asynchronous active-high reset
//   start           in  1          begin a frame (honoured only in IDLE)
//   abort           in  1          synchronous cancel, any state
//   x_max           in  X_BITS     last column, sampled on accepted start
//   y_max           in  Y_BITS     last row, sampled on accepted start
//   out_valid       out 1          beat available
//   out_ready       in  1          consumer accepts beat
//   out_x           out X_BITS     column of lane 0 (lane i is out_x+i)
//   out_y           out Y_BITS     row of the beat
//   out_lane_mask   out NUM_LANES  lanes holding in-frame pixels
//   out_row_last    out 1          beat contains the last column
//   out_frame_last  out 1          beat contains the last pixel of the frame
//   busy            out 1          scanner not idle
//   done            out 1          one-cycle pulse after the final beat
// ---------------------------------------------------------------------------
module pix_scan
   import pix_pkg::*;
#(
   parameter int X_BITS    = PIX_X_BITS,
   parameter int Y_BITS    = PIX_Y_BITS,
   parameter int NUM_LANES = PIX_NUM_LANES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [X_BITS-1:0]    x_max,
   input  logic [Y_BITS-1:0]    y_max,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [X_BITS-1:0]    out_x,
   output logic [Y_BITS-1:0]    out_y,
   output logic [NUM_LANES-1:0] out_lane_mask,
   output logic                 out_row_last,
   output logic                 out_frame_last,
   output logic                 busy,
   output logic                 done
);

   scan_state_t         r_state;
   logic [X_BITS-1:0]   r_xMaxLat;
   logic [Y_BITS-1:0]   r_yMaxLat;
   logic [X_BITS-1:0]   r_outX;
   logic [Y_BITS-1:0]   r_outY;
   logic                r_valid;
   logic                r_busy;
   logic                r_done;

   logic [NUM_LANES-1:0] w_laneMask;
   logic                 w_rowLast;
   logic                 w_frameLast;
   logic                 w_inRun;
   logic                 w_handshake;

   // Lane mask and row boundary are derived from the registered beat
   // position and the latched extent, so they always line up with out_x.
   pix_lane_mask #(
      .X_BITS    (X_BITS),
      .NUM_LANES (NUM_LANES)
   ) u_laneMask (
      .i_baseX    (r_outX),
      .i_xMax     (r_xMaxLat),
      .o_laneMask (w_laneMask),
      .o_rowLast  (w_rowLast)
   );

   assign w_inRun     = (r_state == RUN);
   assign w_frameLast = w_rowLast && (r_outY == r_yMaxLat);
   assign w_handshake = r_valid && out_ready;

   // Scanner FSM. abort wins over everything including a same-cycle start
   // or handshake, so an aborted beat is never advanced past and no done
   // pulse is produced. Beat fields only move on a handshake, which keeps
   // them stable under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_xMaxLat <= '0;
         r_yMaxLat <= '0;
         r_outX    <= '0;
         r_outY    <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (abort) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     r_xMaxLat <= x_max;
                     r_yMaxLat <= y_max;
                     r_outX    <= '0;
                     r_outY    <= '0;
                     r_valid   <= 1'b1;
                     r_busy    <= 1'b1;
                     r_state   <= RUN;
                  end
               end
               RUN: begin
                  if (w_handshake) begin
                     if (w_frameLast) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                     end else if (w_rowLast) begin
                        r_outX <= '0;
                        r_outY <= r_outY + Y_BITS'(1);
                     end else begin
                        r_outX <= r_outX + X_BITS'(NUM_LANES);
                     end
                  end
               end
               DONE: begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
               default: begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   // Boundary flags and the mask are forced low outside RUN so that reset
   // and idle present an all-zero beat even though the mask logic would
   // otherwise flag lane 0 of an empty extent.
   assign out_valid      = r_valid;
   assign out_x          = r_outX;
   assign out_y          = r_outY;
   assign out_lane_mask  = w_inRun ? w_laneMask : '0;
   assign out_row_last   = w_inRun && w_rowLast;
   assign out_frame_last = w_inRun && w_frameLast;
   assign busy           = r_busy;
   assign done           = r_done;

endmodule : pix_scan

// File: tb/tb_pix_scan.sv
// ---------------------------------------------------------------------------
// tb_pix_scan
// Scoreboard bench for pix_scan (NUM_LANES=4). Stimulus pushes the expected
// beats into a queue; an independent monitor pops and compares every beat the
// scanner hands over, and checks that done pulses exactly one cycle after
// the final beat is accepted.
// ---------------------------------------------------------------------------
module tb_pix_scan;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [9:0] x_max;
   logic [9:0] y_max;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out_x;
   logic [9:0] out_y;
   logic [3:0] out_lane_mask;
   logic       out_row_last;
   logic       out_frame_last;
   logic       busy;
   logic       done;

   int          checks    = 0;
   int          errors    = 0;
   int          beatsSeen = 0;
   logic [25:0] expQ[$];
   logic        prevFinal = 1'b0;
   int          cyc;

   pix_scan #(
      .X_BITS    (10),
      .Y_BITS    (10),
      .NUM_LANES (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .x_max          (x_max),
      .y_max          (y_max),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_x          (out_x),
      .out_y          (out_y),
      .out_lane_mask  (out_lane_mask),
      .out_row_last   (out_row_last),
      .out_frame_last (out_frame_last),
      .busy           (busy),
      .done           (done)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic a, input logic rdy,
                                input logic [9:0] xm, input logic [9:0] ym);
      start     = s;
      abort     = a;
      out_ready = rdy;
      x_max     = xm;
      y_max     = ym;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pushBeat(input logic [9:0] x, input logic [9:0] y, input logic [3:0] m,
                           input logic rl, input logic fl);
      expQ.push_back({x, y, m, rl, fl});
   endtask

   // Hand-computed beats for a 10x2 frame scanned four lanes at a time.
   task automatic pushFrame9x1();
      pushBeat(10'd0, 10'd0, 4'b1111, 1'b0, 1'b0);
      pushBeat(10'd4, 10'd0, 4'b1111, 1'b0, 1'b0);
      pushBeat(10'd8, 10'd0, 4'b0011, 1'b1, 1'b0);
      pushBeat(10'd0, 10'd1, 4'b1111, 1'b0, 1'b0);
      pushBeat(10'd4, 10'd1, 4'b1111, 1'b0, 1'b0);
      pushBeat(10'd8, 10'd1, 4'b0011, 1'b1, 1'b1);
   endtask

   // Steps until done is seen; cycles reports how many steps it took.
   task automatic waitDone(input int limit, output int cycles);
      cycles = -1;
      for (int c = 1; c <= limit && cycles < 0; c++) begin
         stepCycle();
         if (done === 1'b1) cycles = c;
      end
      if (cycles < 0) checkOutput("done_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic finishFrame(input string tag, input int expBeats);
      checkOutput({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
      stepCycle();
      checkOutput({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_busy_cleared"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_valid_cleared"}, {31'd0, out_valid}, 32'd0);
      checkOutput({tag, "_queue_empty"}, expQ.size(), 32'd0);
      checkOutput({tag, "_beat_count"}, beatsSeen, expBeats);
      beatsSeen = 0;
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         prevFinal = 1'b0;
      end else begin
         if (done || prevFinal) checkOutput("done_pulse", {31'd0, done}, {31'd0, prevFinal});
         if (out_valid) checkOutput("busy_with_valid", {31'd0, busy}, 32'd1);
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_beat", {6'd0, out_x, out_y, out_lane_mask,
                           out_row_last, out_frame_last}, 32'hFFFF_FFFF);
            end else begin
               checkOutput("beat", {6'd0, out_x, out_y, out_lane_mask, out_row_last,
                           out_frame_last}, {6'd0, expQ.pop_front()});
            end
            beatsSeen++;
         end
         prevFinal = out_valid && out_ready && out_frame_last && !abort;
      end
   end

   // Watchdog in case the stimulus thread ever stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset state
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outputs", {18'd0, out_valid, out_x, out_y, out_lane_mask,
                  out_row_last, out_frame_last, busy, done}, 32'd0);
      rst = 1'b0;
      stepCycle();
      stepCycle();

      // Test 1: 10x2 frame, full throughput
      pushFrame9x1();
      checkOutput("t1_valid_before_start", {31'd0, out_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 10'd9, 10'd1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd9, 10'd1);
      checkOutput("t1_valid_after_start", {31'd0, out_valid}, 32'd1);
      checkOutput("t1_busy_after_start", {31'd0, busy}, 32'd1);
      waitDone(50, cyc);
      checkOutput("t1_cycles_to_done", cyc, 32'd6);
      finishFrame("t1", 6);

      // Test 2: 1x1 frame
      pushBeat(10'd0, 10'd0, 4'b0001, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 10'd0, 10'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
      waitDone(20, cyc);
      checkOutput("t2_cycles_to_done", cyc, 32'd1);
      finishFrame("t2", 1);

      // Test 3: backpressure on beat (4,0) for three cycles
      pushFrame9x1();
      applyStimulus(1'b1, 1'b0, 1'b1, 10'd9, 10'd1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd9, 10'd1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 10'd9, 10'd1);
      for (int k = 0; k < 3; k++) begin
         checkOutput("t3_held_beat", {11'd0, out_valid, out_x, out_y, out_lane_mask},
                     {11'd0, 1'b1, 10'd4, 10'd0, 4'b1111});
         stepCycle();
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd9, 10'd1);
      checkOutput("t3_held_beat_release", {11'd0, out_valid, out_x, out_y, out_lane_mask},
                  {11'd0, 1'b1, 10'd4, 10'd0, 4'b1111});
      waitDone(50, cyc);
      checkOutput("t3_cycles_to_done", cyc, 32'd5);
      finishFrame("t3", 6);

      // Test 4: abort on handshake of beat (4,1), then a fresh 4x1 frame
      pushBeat(10'd0, 10'd0, 4'b1111, 1'b0, 1'b0);
      pushBeat(10'd4, 10'd0, 4'b1111, 1'b0, 1'b0);
      pushBeat(10'd8, 10'd0, 4'b0011, 1'b1, 1'b0);
      pushBeat(10'd0, 10'd1, 4'b1111, 1'b0, 1'b0);
      pushBeat(10'd4, 10'd1, 4'b1111, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 10'd9, 10'd1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd9, 10'd1);
      repeat (4) stepCycle();
      checkOutput("t4_pre_abort_pos", {12'd0, out_x, out_y}, {12'd0, 10'd4, 10'd1});
      applyStimulus(1'b0, 1'b1, 1'b1, 10'd9, 10'd1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd9, 10'd1);
      checkOutput("t4_valid_after_abort", {31'd0, out_valid}, 32'd0);
      checkOutput("t4_busy_after_abort", {31'd0, busy}, 32'd0);
      checkOutput("t4_done_after_abort", {31'd0, done}, 32'd0);
      stepCycle();
      checkOutput("t4_no_late_done", {31'd0, done}, 32'd0);
      checkOutput("t4_queue_empty", expQ.size(), 32'd0);
      checkOutput("t4_beats_before_abort", beatsSeen, 32'd5);
      beatsSeen = 0;
      pushBeat(10'd0, 10'd0, 4'b1111, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 10'd3, 10'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd3, 10'd0);
      waitDone(20, cyc);
      checkOutput("t4_restart_cycles", cyc, 32'd1);
      finishFrame("t4", 1);

      // Test 5: start re-pulsed with a new x_max mid-frame is ignored
      pushFrame9x1();
      applyStimulus(1'b1, 1'b0, 1'b1, 10'd9, 10'd1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd9, 10'd1);
      stepCycle();
      applyStimulus(1'b1, 1'b0, 1'b1, 10'd20, 10'd1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd20, 10'd1);
      waitDone(50, cyc);
      checkOutput("t5_cycles_to_done", cyc, 32'd4);
      finishFrame("t5", 6);

      // Test 6: asynchronous reset mid-frame
      pushBeat(10'd0, 10'd0, 4'b1111, 1'b0, 1'b0);
      pushBeat(10'd4, 10'd0, 4'b1111, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 10'd9, 10'd1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd9, 10'd1);
      stepCycle();
      stepCycle();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t6_async_reset_outputs", {18'd0, out_valid, out_x, out_y, out_lane_mask,
                  out_row_last, out_frame_last, busy, done}, 32'd0);
      stepCycle();
      rst = 1'b0;
      checkOutput("t6_queue_empty", expQ.size(), 32'd0);
      checkOutput("t6_beats_before_reset", beatsSeen, 32'd2);
      beatsSeen = 0;
      for (int k = 0; k < 3; k++) begin
         stepCycle();
         checkOutput("t6_idle_waits", {30'd0, out_valid, busy}, 32'd0);
      end
      pushBeat(10'd0, 10'd0, 4'b0001, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 10'd0, 10'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
      waitDone(20, cyc);
      checkOutput("t6_restart_cycles", cyc, 32'd1);
      finishFrame("t6", 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pix_scan
